// File: rtl/nvram_pkg.sv
// nvram_pkg: shared state encoding and constants for the NVRAM arbiter
package nvram_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE    = 3'd0;
    localparam state_t DRAIN   = 3'd1;
    localparam state_t DL      = 3'd2;
    localparam state_t UL_ADDR = 3'd3;
    localparam state_t UL_READ = 3'd4;
    localparam state_t UL_HOLD = 3'd5;
    localparam state_t RELEASE = 3'd6;
    localparam logic [7:0] BLANK_BYTE = 8'hFF;
endpackage

// File: rtl/nvram_port_mux.sv
// nvram_port_mux: selects CPU or host as the owner of the NVRAM port
module nvram_port_mux
    import nvram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              host_busy,
    input  state_t            state,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_di,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_di,
    input  logic              host_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_di,
    output logic              mem_we
);
    // CPU writes only while idle; host writes only while downloading
    always_comb begin
        mem_addr = host_busy ? host_addr : cpu_addr;
        mem_di   = host_busy ? host_di : cpu_di;
        mem_we   = (state == IDLE) ? (cpu_cs & cpu_we) : (host_busy && state == DL) ? host_we : 1'b0;
    end
endmodule

// File: rtl/nvram_arbiter.sv
// nvram_arbiter: shares the NVRAM port between the game CPU and the ioctl host
module nvram_arbiter
    import nvram_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int NV_INDEX     = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int READ_LAT     = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_upload,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_di,
    output logic [7:0]        cpu_do,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_di,
    output logic              mem_we,
    input  logic [7:0]        mem_do,
    output logic              cpu_pause,
    output logic              host_busy,
    output logic              nv_dirty
);
    state_t      state;
    logic [3:0]  cnt;
    logic        wait_r;
    logic [24:0] last_addr;
    logic        dl_req, ul_req, in_range;

    assign dl_req     = ioctl_download && ioctl_index == 8'(NV_INDEX);
    assign ul_req     = ioctl_upload && ioctl_index == 8'(NV_INDEX);
    assign in_range   = ioctl_addr[24:ADDR_W] == '0;
    assign ioctl_wait = wait_r | (state == UL_HOLD && ioctl_addr != last_addr);
    assign cpu_do     = mem_do;

    nvram_port_mux #(.ADDR_W(ADDR_W)) u_mux (
        .host_busy(host_busy),
        .state(state),
        .cpu_cs(cpu_cs),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_di(cpu_di),
        .host_addr(ioctl_addr[ADDR_W-1:0]),
        .host_di(ioctl_dout),
        .host_we(ioctl_wr & in_range),
        .mem_addr(mem_addr),
        .mem_di(mem_di),
        .mem_we(mem_we)
    );

    // session FSM: pause, drain, serve host bytes, hand the port back
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cpu_pause <= 1'b0;
            host_busy <= 1'b0;
            wait_r    <= 1'b0;
            ioctl_din <= BLANK_BYTE;
            nv_dirty  <= 1'b0;
            last_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_cs && cpu_we) nv_dirty <= 1'b1;
                    if (dl_req || ul_req) begin
                        state     <= DRAIN;
                        cpu_pause <= 1'b1;
                        wait_r    <= 1'b1;
                        cnt       <= 4'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (!(dl_req || ul_req)) begin
                        state  <= RELEASE;
                        wait_r <= 1'b0;
                    end else if (cnt == '0) begin
                        state     <= dl_req ? DL : UL_ADDR;
                        host_busy <= 1'b1;
                        wait_r    <= !dl_req;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DL: begin
                    if (!dl_req) begin
                        nv_dirty  <= 1'b0;
                        host_busy <= 1'b0;
                        state     <= RELEASE;
                    end
                end
                UL_ADDR: begin
                    wait_r <= 1'b1;
                    cnt    <= 4'(READ_LAT);
                    state  <= UL_READ;
                end
                UL_READ: begin
                    if (cnt < 4'd2) begin
                        ioctl_din <= in_range ? mem_do : BLANK_BYTE;
                        wait_r    <= 1'b0;
                        last_addr <= ioctl_addr;
                        state     <= UL_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                UL_HOLD: begin
                    if (!ul_req) begin
                        nv_dirty  <= 1'b0;
                        host_busy <= 1'b0;
                        state     <= RELEASE;
                    end else if (ioctl_addr != last_addr) begin
                        wait_r <= 1'b1;
                        state  <= UL_ADDR;
                    end
                end
                RELEASE: begin
                    cpu_pause <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nvram_arbiter.sv
// tb_nvram_arbiter: directed vectors and session sequences for nvram_arbiter
module tb_nvram_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0, ioctl_upload = 1'b0, ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        cpu_cs = 1'b0, cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [7:0]  cpu_di = 8'd0;
    logic [7:0]  cpu_do;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_di;
    logic        mem_we;
    logic [7:0]  mem_do;
    logic        cpu_pause, host_busy, nv_dirty;
    logic [7:0]  mem [0:1023];
    int          errors = 0, checks = 0;

    typedef struct {
        logic       cs, we;
        logic [9:0] addr;
        logic [7:0] di;
        logic       dl;
        logic [7:0] idx;
        logic       exp_we, exp_dirty;
    } vec_t;
    vec_t tv [5];

    nvram_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_do(cpu_do),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_we(mem_we), .mem_do(mem_do),
        .cpu_pause(cpu_pause), .host_busy(host_busy), .nv_dirty(nv_dirty)
    );

    // clock
    always #5 clk_sys = ~clk_sys;

    // 1-cycle-latency synchronous RAM model
    always @(posedge clk_sys) begin
        if (mem_we) mem[mem_addr] <= mem_di;
        mem_do <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (!host_busy && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic count_wait(output int n);
        n = 0;
        while (ioctl_wait && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        logic [24:0] ua [4];
        logic [7:0]  ud [4];
        ua[0] = 25'h100; ua[1] = 25'h101; ua[2] = 25'h102; ua[3] = 25'h400;
        ud[0] = 8'hA1;   ud[1] = 8'hB2;   ud[2] = 8'hC3;   ud[3] = 8'hFF;
        tv[0] = '{1'b0, 1'b1, 10'h030, 8'h99, 1'b0, 8'd4, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b0, 10'h020, 8'h00, 1'b0, 8'd4, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b0, 10'h040, 8'h00, 1'b1, 8'd3, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b1, 10'h010, 8'h5A, 1'b0, 8'd0, 1'b1, 1'b1};
        tv[4] = '{1'b1, 1'b1, 10'h3FF, 8'hC3, 1'b1, 8'd3, 1'b1, 1'b1};

        tick(); tick();
        chk("rst cpu_pause", cpu_pause, 0);
        chk("rst host_busy", host_busy, 0);
        chk("rst ioctl_wait", ioctl_wait, 0);
        chk("rst nv_dirty", nv_dirty, 0);
        chk("rst ioctl_din", ioctl_din, 8'hFF);
        chk("rst mem_we", mem_we, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            cpu_cs = tv[i].cs; cpu_we = tv[i].we; cpu_addr = tv[i].addr; cpu_di = tv[i].di;
            ioctl_download = tv[i].dl; ioctl_index = tv[i].idx;
            #1;
            chk($sformatf("vec%0d mem_we", i), mem_we, tv[i].exp_we);
            chk($sformatf("vec%0d mem_addr", i), mem_addr, tv[i].addr);
            chk($sformatf("vec%0d mem_di", i), mem_di, tv[i].di);
            tick();
            chk($sformatf("vec%0d cpu_pause", i), cpu_pause, 0);
            chk($sformatf("vec%0d nv_dirty", i), nv_dirty, tv[i].exp_dirty);
        end
        ioctl_download = 1'b0; ioctl_index = 8'd0;
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        tick();
        chk("cpu readback 010", cpu_do, 8'h5A);
        cpu_cs = 1'b0;

        ioctl_download = 1'b1; ioctl_index = 8'd4; ioctl_addr = '0;
        tick();
        chk("dl cpu_pause", cpu_pause, 1);
        chk("dl drain wait", ioctl_wait, 1);
        chk("dl drain busy", host_busy, 0);
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h050; cpu_di = 8'hEE;
        #1;
        chk("drain blocks cpu we", mem_we, 0);
        cpu_cs = 1'b0; cpu_we = 1'b0;
        wait_grant(n);
        chk("dl grant latency", n, 5);
        chk("dl wait low", ioctl_wait, 0);
        ioctl_addr = 25'h0; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
        #1;
        chk("dl wr0 mem_we", mem_we, 1);
        chk("dl wr0 mem_addr", mem_addr, 0);
        chk("dl wr0 mem_di", mem_di, 8'h11);
        tick();
        ioctl_wr = 1'b0;
        #1;
        chk("dl we single cycle", mem_we, 0);
        ioctl_addr = 25'h1; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
        #1;
        chk("dl wr1 mem_we", mem_we, 1);
        chk("dl wr1 mem_addr", mem_addr, 1);
        tick();
        ioctl_addr = 25'h400; ioctl_dout = 8'h33;
        #1;
        chk("dl oor dropped", mem_we, 0);
        tick();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        tick();
        chk("dl release busy", host_busy, 0);
        chk("dl dirty cleared", nv_dirty, 0);
        chk("dl release pause", cpu_pause, 1);
        tick();
        chk("dl pause dropped", cpu_pause, 0);
        cpu_cs = 1'b1; cpu_addr = 10'h001;
        tick();
        chk("mem[1]", cpu_do, 8'h22);
        cpu_addr = 10'h000;
        tick();
        chk("mem[0]", cpu_do, 8'h11);

        cpu_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_addr = 10'(ua[i]); cpu_di = ud[i];
            tick();
        end
        cpu_cs = 1'b0; cpu_we = 1'b0;
        chk("preload dirty", nv_dirty, 1);

        ioctl_upload = 1'b1; ioctl_addr = ua[0];
        tick();
        wait_grant(n);
        chk("ul grant latency", n, 5);
        count_wait(n);
        chk("ul byte0 wait cycles", n, 2);
        chk("ul byte0 din", ioctl_din, ud[0]);
        for (int i = 1; i < 4; i++) begin
            ioctl_addr = ua[i];
            #1;
            chk($sformatf("ul byte%0d wait rise", i), ioctl_wait, 1);
            tick();
            count_wait(n);
            chk($sformatf("ul byte%0d wait cycles", i), n, 2);
            chk($sformatf("ul byte%0d din", i), ioctl_din, ud[i]);
        end
        ioctl_upload = 1'b0;
        tick();
        chk("ul release busy", host_busy, 0);
        chk("ul dirty cleared", nv_dirty, 0);
        tick();
        chk("ul pause dropped", cpu_pause, 0);

        ioctl_download = 1'b1; ioctl_upload = 1'b1; ioctl_addr = 25'h5;
        tick();
        wait_grant(n);
        chk("both grant latency", n, 5);
        chk("both takes dl wait", ioctl_wait, 0);
        ioctl_dout = 8'h77; ioctl_wr = 1'b1;
        #1;
        chk("both dl write", mem_we, 1);
        tick();
        ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_upload = 1'b0;
        tick(); tick();
        chk("both back idle", cpu_pause, 0);

        ioctl_upload = 1'b1; ioctl_addr = ua[1];
        tick();
        wait_grant(n);
        count_wait(n);
        chk("mid din before rst", ioctl_din, ud[1]);
        ioctl_addr = ua[2];
        tick(); tick();
        chk("mid in ul_read wait", ioctl_wait, 1);
        reset = 1'b1; ioctl_upload = 1'b0;
        tick();
        chk("mid rst wait", ioctl_wait, 0);
        chk("mid rst pause", cpu_pause, 0);
        chk("mid rst din", ioctl_din, 8'hFF);
        chk("mid rst busy", host_busy, 0);
        reset = 1'b0;
        tick();
        chk("post rst idle", cpu_pause, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
